traffic_light_ctrl: RTL

Parametrised two-road intersection controller. It is the successor to the fixed 4-phase lab controller and sequences green, yellow and all-red clearance per road, with per-phase durations set by parameters. It adds pause, emergency all-red hold and a night flashing-yellow mode. It drives BCD countdown digits for the existing BCD 7-segment decoders and 3-bit lamp vectors per road.

---
 rtl/traffic_light_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl
//
// Two-road intersection controller. The sequence is green, yellow and all-red
// clearance for each road. Each phase lasts a whole number of one-second ticks,
// and the per-phase lengths are set by parameters. The block also provides:
//   - pause      : freezes all sequencing.
//   - estop      : forces an all-red emergency hold and shows code A/A.
//   - night mode : flashing yellow on both roads, entered at a clearance
//                  boundary.
// The remaining seconds of the current phase are shown as two BCD digits for
// the downstream 7-segment decoders.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset (returns to IDLE)
//   start    in   level; leaves IDLE (ignored in every other state)
//   pause    in   level; freezes state, prescaler, remaining and flash
//   estop    in   level; all-red hold with A/A display, everything frozen
//   night    in   level; requests flashing-yellow mode
//   led_a    out  road A lamps {red, green, yellow}
//   led_b    out  road B lamps {red, green, yellow}
//   disp_hi  out  BCD tens of remaining seconds (A = estop, F = blank)
//   disp_lo  out  BCD units of remaining seconds (same codes)
//   phase_o  out  current state encoding, for debug
// ----------------------------------------------------------------------------
module traffic_light_ctrl #(
    parameter int unsigned TICK_DIV     = 10_000_000,
    parameter int unsigned A_GREEN_SEC  = 30,
    parameter int unsigned A_YELLOW_SEC = 5,
    parameter int unsigned B_GREEN_SEC  = 20,
    parameter int unsigned B_YELLOW_SEC = 5,
    parameter int unsigned ALL_RED_SEC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       estop,
    input  logic       night,
    output logic [2:0] led_a,
    output logic [2:0] led_b,
    output logic [3:0] disp_hi,
    output logic [3:0] disp_lo,
    output logic [2:0] phase_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Phase durations pre-converted to two BCD digits.
    localparam logic [7:0] LD_A_GRN = {4'(A_GREEN_SEC / 10),  4'(A_GREEN_SEC % 10)};
    localparam logic [7:0] LD_A_YEL = {4'(A_YELLOW_SEC / 10), 4'(A_YELLOW_SEC % 10)};
    localparam logic [7:0] LD_B_GRN = {4'(B_GREEN_SEC / 10),  4'(B_GREEN_SEC % 10)};
    localparam logic [7:0] LD_B_YEL = {4'(B_YELLOW_SEC / 10), 4'(B_YELLOW_SEC % 10)};
    localparam logic [7:0] LD_RED   = {4'(ALL_RED_SEC / 10),  4'(ALL_RED_SEC % 10)};

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_GRN = 3'b010;
    localparam logic [2:0] LAMP_YEL = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_A_GRN = 3'd1,
        S_A_YEL = 3'd2,
        S_RED1  = 3'd3,
        S_B_GRN = 3'd4,
        S_B_YEL = 3'd5,
        S_RED2  = 3'd6,
        S_NIGHT = 3'd7
    } state_t;

    state_t        state, state_nxt, tgt;
    logic [PW-1:0] presc, presc_nxt;
    logic [7:0]    rem, rem_nxt;
    logic          flash, flash_nxt;
    logic          tick;
    logic          do_enter;

    logic [2:0]    led_a_r, led_b_r;
    logic [7:0]    disp_r;

    // Duration loaded on entry to a state; NIGHT has no countdown.
    function automatic logic [7:0] load_for(input state_t s);
        case (s)
            S_A_GRN: return LD_A_GRN;
            S_A_YEL: return LD_A_YEL;
            S_RED1:  return LD_RED;
            S_B_GRN: return LD_B_GRN;
            S_B_YEL: return LD_B_YEL;
            S_RED2:  return LD_RED;
            default: return 8'h00;
        endcase
    endfunction

    // One-second BCD decrement; only called with a value above 01.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [2:0] lamps_a(input state_t s, input logic f);
        case (s)
            S_A_GRN: return LAMP_GRN;
            S_A_YEL: return LAMP_YEL;
            S_NIGHT: return {2'b00, f};
            default: return LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] lamps_b(input state_t s, input logic f);
        case (s)
            S_B_GRN: return LAMP_GRN;
            S_B_YEL: return LAMP_YEL;
            S_NIGHT: return {2'b00, f};
            default: return LAMP_RED;
        endcase
    endfunction

    function automatic logic [7:0] disp_for(input state_t s, input logic [7:0] r);
        case (s)
            S_IDLE:  return 8'h00;
            S_NIGHT: return 8'hFF;
            default: return r;
        endcase
    endfunction

    // The prescaler only runs outside IDLE, so a tick never fires there.
    assign tick = (state != S_IDLE) && (presc == TICK_LAST);

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        rem_nxt   = rem;
        flash_nxt = flash;
        tgt       = state;
        do_enter  = 1'b0;

        // estop and pause both freeze every piece of state.
        if (!estop && !pause) begin
            if (state != S_IDLE) begin
                presc_nxt = tick ? '0 : presc + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        do_enter = 1'b1;
                        tgt      = night ? S_NIGHT : S_A_GRN;
                    end
                end
                S_NIGHT: begin
                    if (tick) begin
                        if (night) begin
                            flash_nxt = ~flash;
                        end else begin
                            do_enter = 1'b1;
                            tgt      = S_A_GRN;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (rem > 8'h01) begin
                            rem_nxt = bcd_dec(rem);
                        end else begin
                            do_enter = 1'b1;
                            // Night is only honoured at the end of a
                            // clearance, i.e. just before a green would start.
                            case (state)
                                S_A_GRN: tgt = S_A_YEL;
                                S_A_YEL: tgt = (ALL_RED_SEC == 0) ?
                                               (night ? S_NIGHT : S_B_GRN) : S_RED1;
                                S_RED1:  tgt = night ? S_NIGHT : S_B_GRN;
                                S_B_GRN: tgt = S_B_YEL;
                                S_B_YEL: tgt = (ALL_RED_SEC == 0) ?
                                               (night ? S_NIGHT : S_A_GRN) : S_RED2;
                                S_RED2:  tgt = night ? S_NIGHT : S_A_GRN;
                                default: tgt = S_IDLE;
                            endcase
                        end
                    end
                end
            endcase

            // Every state entry restarts the second count from zero.
            if (do_enter) begin
                state_nxt = tgt;
                presc_nxt = '0;
                rem_nxt   = load_for(tgt);
                flash_nxt = 1'b0;
            end
        end
    end

    // The lamp and display registers are loaded from the next-state values,
    // so they always match the state register in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            presc   <= '0;
            rem     <= 8'h00;
            flash   <= 1'b0;
            led_a_r <= LAMP_RED;
            led_b_r <= LAMP_RED;
            disp_r  <= 8'h00;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            rem     <= rem_nxt;
            flash   <= flash_nxt;
            led_a_r <= lamps_a(state_nxt, flash_nxt);
            led_b_r <= lamps_b(state_nxt, flash_nxt);
            disp_r  <= disp_for(state_nxt, rem_nxt);
        end
    end

    // The estop override is combinational so that the lamps drop to red in
    // the same cycle that estop is asserted.
    assign led_a   = estop ? LAMP_RED : led_a_r;
    assign led_b   = estop ? LAMP_RED : led_b_r;
    assign disp_hi = estop ? 4'hA : disp_r[7:4];
    assign disp_lo = estop ? 4'hA : disp_r[3:0];
    assign phase_o = state;

endmodule
